// File: rtl/mem_bus_arbiter.sv
// Two-way round-robin arbiter sharing one memory bus between the I-cache refill port and
// the data-memory port. Bus fields are latched on grant and held until completion or timeout.
module mem_bus_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ic_req,
    input  logic [XLEN-1:0] i_ic_addr,
    output logic [XLEN-1:0] o_ic_data,
    output logic            o_ic_ready,
    input  logic            i_dm_rd,
    input  logic            i_dm_wr,
    input  logic [XLEN-1:0] i_dm_addr,
    input  logic [XLEN-1:0] i_dm_wd,
    input  logic [3:0]      i_dm_byte_en,
    output logic [XLEN-1:0] o_dm_rdata,
    output logic            o_dm_ready,
    output logic            o_mem_req,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wd,
    output logic [3:0]      o_mem_byte_en,
    input  logic [XLEN-1:0] i_mem_rdata,
    input  logic            i_mem_ready,
    output logic            o_err,
    output logic            o_owner
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StBusyIc, StBusyDm, StResp} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            dm_req;
    logic            grant_dm;
    logic            expired;

    assign dm_req = i_dm_rd | i_dm_wr;

    // o_owner doubles as the round-robin history bit.
    always_comb begin
        grant_dm = dm_req & (~i_ic_req | ~o_owner);
    end

    if (TIMEOUT != 0) begin : g_timeout
        assign expired = (32'(cnt_q) == TIMEOUT - 1);
    end else begin : g_no_timeout
        assign expired = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            o_ic_data     <= '0;
            o_ic_ready    <= 1'b0;
            o_dm_rdata    <= '0;
            o_dm_ready    <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_wen     <= 1'b0;
            o_mem_addr    <= '0;
            o_mem_wd      <= '0;
            o_mem_byte_en <= '0;
            o_err         <= 1'b0;
            o_owner       <= 1'b0;
        end else begin
            o_ic_ready <= 1'b0;
            o_dm_ready <= 1'b0;
            o_err      <= 1'b0;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (i_ic_req || dm_req) begin
                        o_mem_req <= 1'b1;
                        if (grant_dm) begin
                            state_q       <= StBusyDm;
                            o_owner       <= 1'b1;
                            o_mem_wen     <= i_dm_wr;
                            o_mem_addr    <= i_dm_addr;
                            o_mem_wd      <= i_dm_wd;
                            o_mem_byte_en <= i_dm_byte_en;
                        end else begin
                            state_q       <= StBusyIc;
                            o_owner       <= 1'b0;
                            o_mem_wen     <= 1'b0;
                            o_mem_addr    <= i_ic_addr;
                            o_mem_wd      <= '0;
                            o_mem_byte_en <= 4'hF;
                        end
                    end
                end
                StBusyIc, StBusyDm: begin
                    // Completion takes priority over a timeout expiring in the same cycle.
                    if (i_mem_ready || expired) begin
                        o_mem_req <= 1'b0;
                        o_err     <= ~i_mem_ready;
                        state_q   <= StResp;
                        if (state_q == StBusyIc) begin
                            o_ic_ready <= 1'b1;
                            o_ic_data  <= i_mem_ready ? i_mem_rdata : '0;
                        end else begin
                            o_dm_ready <= 1'b1;
                            o_dm_rdata <= (i_mem_ready && !o_mem_wen) ? i_mem_rdata : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StResp: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: stimulus pushes expected responses into a queue and a
// negedge monitor pops and checks each ready pulse.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic [31:0] ic_data;
    logic        ic_ready;
    logic        dm_rd;
    logic        dm_wr;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        err;
    logic        owner;

    typedef struct {
        logic        dm;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_bus_arbiter #(
        .XLEN    (32),
        .TIMEOUT (8)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ic_req      (ic_req),
        .i_ic_addr     (ic_addr),
        .o_ic_data     (ic_data),
        .o_ic_ready    (ic_ready),
        .i_dm_rd       (dm_rd),
        .i_dm_wr       (dm_wr),
        .i_dm_addr     (dm_addr),
        .i_dm_wd       (dm_wd),
        .i_dm_byte_en  (dm_be),
        .o_dm_rdata    (dm_rdata),
        .o_dm_ready    (dm_ready),
        .o_mem_req     (mem_req),
        .o_mem_wen     (mem_wen),
        .o_mem_addr    (mem_addr),
        .o_mem_wd      (mem_wd),
        .o_mem_byte_en (mem_be),
        .i_mem_rdata   (mem_rdata),
        .i_mem_ready   (mem_ready),
        .o_err         (err),
        .o_owner       (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && (ic_ready || dm_ready)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready: ic=%b dm=%b, expected no pulse at %0t",
                         ic_ready, dm_ready, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check1("resp_port_dm", dm_ready, e.dm);
                check1("resp_port_ic", ic_ready, ~e.dm);
                check32("resp_data", e.dm ? dm_rdata : ic_data, e.data);
                check1("resp_err", err, e.err);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ic_req    = 1'b0;
        ic_addr   = '0;
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wd     = '0;
        dm_be     = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        clear_inputs();
        #10;
        rst = 1'b0;
        tick(1);
    endtask

    // Memory answers in the current cycle; returns in the IDLE cycle after RESP.
    task automatic complete(input logic dm, input logic [31:0] rdata, input logic [31:0] exp_data);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        exp_q.push_back('{dm, exp_data, 1'b0});
        tick(1);
        mem_ready = 1'b0;
        mem_rdata = '0;
        if (dm) begin
            dm_rd = 1'b0;
            dm_wr = 1'b0;
        end else begin
            ic_req = 1'b0;
        end
        check1("req_low_after_ready", mem_req, 1'b0);
        tick(1);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #12;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_owner", owner, 1'b0);
        check1("rst_err", err, 1'b0);
        check32("rst_mem_addr", mem_addr, 32'h0);
        check32("rst_ic_data", ic_data, 32'h0);
        rst = 1'b0;
        tick(1);

        // 1: IC only, memory answers 3 cycles after o_mem_req
        ic_req  = 1'b1;
        ic_addr = 32'h100;
        tick(1);
        check1("t1_req", mem_req, 1'b1);
        check32("t1_addr", mem_addr, 32'h100);
        check32("t1_be", {28'h0, mem_be}, 32'hF);
        check1("t1_wen", mem_wen, 1'b0);
        check1("t1_owner", owner, 1'b0);
        tick(2);
        check1("t1_req_held", mem_req, 1'b1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 32'hDEADBEEF, 1'b0});
        tick(1);
        mem_ready = 1'b0;
        check1("t1_req_drop", mem_req, 1'b0);
        tick(1);
        ic_req = 1'b0;
        check1("t1_no_reissue", mem_req, 1'b0);
        tick(1);
        check1("t1_idle", mem_req, 1'b0);

        // 2: tie from reset goes to DM, then IC
        do_reset();
        ic_req  = 1'b1;
        ic_addr = 32'h200;
        dm_rd   = 1'b1;
        dm_addr = 32'h300;
        dm_be   = 4'b0011;
        tick(1);
        check1("t2_owner_dm", owner, 1'b1);
        check32("t2_addr_dm", mem_addr, 32'h300);
        check32("t2_be_dm", {28'h0, mem_be}, 32'h3);
        check1("t2_wen_dm", mem_wen, 1'b0);
        complete(1'b1, 32'h11112222, 32'h11112222);
        check1("t2_gap", mem_req, 1'b0);
        tick(1);
        check1("t2_owner_ic", owner, 1'b0);
        check32("t2_addr_ic", mem_addr, 32'h200);
        complete(1'b0, 32'h33334444, 32'h33334444);

        // 3: DM write held stable while ready is delayed 5 cycles
        dm_wr   = 1'b1;
        dm_addr = 32'h2004;
        dm_wd   = 32'h0000_00AA;
        dm_be   = 4'b0001;
        tick(1);
        dm_addr = 32'hFFFF_0000;
        dm_wd   = 32'h55;
        dm_be   = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            check1("t3_wen", mem_wen, 1'b1);
            check32("t3_addr", mem_addr, 32'h2004);
            check32("t3_wd", mem_wd, 32'hAA);
            check32("t3_be", {28'h0, mem_be}, 32'h1);
            tick(1);
        end
        complete(1'b1, 32'hCAFEF00D, 32'h0);

        // 2b: last owner is DM, so a tie now goes to IC, then DM
        ic_req  = 1'b1;
        ic_addr = 32'h240;
        dm_rd   = 1'b1;
        dm_addr = 32'h340;
        dm_be   = 4'b1111;
        tick(1);
        check1("t2b_owner_ic", owner, 1'b0);
        check32("t2b_addr_ic", mem_addr, 32'h240);
        complete(1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tick(1);
        check1("t2b_owner_dm", owner, 1'b1);
        check32("t2b_addr_dm", mem_addr, 32'h340);
        complete(1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A);

        // 4: timeout with no memory answer
        ic_req  = 1'b1;
        ic_addr = 32'h400;
        tick(1);
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        tick(7);
        check1("t4_req_before_expiry", mem_req, 1'b1);
        check1("t4_no_early_err", err, 1'b0);
        tick(1);
        check1("t4_err", err, 1'b1);
        check1("t4_req_low", mem_req, 1'b0);
        ic_req = 1'b0;
        tick(1);
        check1("t4_err_pulse", err, 1'b0);

        // 4b: ready on the expiry cycle completes normally
        ic_req  = 1'b1;
        ic_addr = 32'h480;
        tick(8);
        complete(1'b0, 32'h0BADCAFE, 32'h0BADCAFE);

        // 5: reset mid-BUSY_DM
        dm_rd   = 1'b1;
        dm_addr = 32'h500;
        dm_be   = 4'b1111;
        tick(1);
        check1("t5_busy", mem_req, 1'b1);
        #2;
        rst   = 1'b1;
        dm_rd = 1'b0;
        #1;
        check1("t5_async_drop", mem_req, 1'b0);
        check1("t5_owner_rst", owner, 1'b0);
        #2;
        rst = 1'b0;
        tick(1);
        mem_ready = 1'b1;
        mem_rdata = 32'h99999999;
        tick(1);
        mem_ready = 1'b0;
        check1("t5_late_ready_dm", dm_ready, 1'b0);
        check1("t5_late_ready_req", mem_req, 1'b0);
        ic_req  = 1'b1;
        ic_addr = 32'h600;
        tick(1);
        check1("t5_new_req", mem_req, 1'b1);
        check32("t5_new_addr", mem_addr, 32'h600);
        complete(1'b0, 32'h600D600D, 32'h600D600D);

        // 6: spurious ready in IDLE, then requester drops mid-BUSY
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick(1);
        mem_ready = 1'b0;
        check1("t6_spur_req", mem_req, 1'b0);
        check1("t6_spur_ic_ready", ic_ready, 1'b0);
        check32("t6_spur_ic_data", ic_data, 32'h600D600D);
        check32("t6_spur_dm_data", dm_rdata, 32'h0);
        dm_rd   = 1'b1;
        dm_addr = 32'h700;
        tick(1);
        dm_rd = 1'b0;
        tick(2);
        check1("t6_drop_req_held", mem_req, 1'b1);
        check32("t6_drop_addr", mem_addr, 32'h700);
        complete(1'b1, 32'h77777777, 32'h77777777);
        tick(3);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
